vga_scanner: RTL and testbench
==============================

# vga_scanner

Raster initiator for the display path. Generates 640×480 VGA timing and drives pixel coordinates to a frame/display ROM. Samples the returned 24-bit colour after a configurable latency and emits a pixel-aligned RGB, sync and blank bundle to the VGA DAC. It is the requesting end of the coordinate→RGB lookup interface served by the display ROMs.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- LATENCY, 0, pixel ticks from o_x/o_y to valid i_rgb; legal range 0..3

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_en  in  1  pixel tick; all state advances only on i_clk edges with i_en=1
- o_x  out  10  requested column, 0..H_ACTIVE-1
- o_y  out  9  requested row, 0..V_ACTIVE-1
- o_req  out  1  o_x/o_y address a visible pixel
- i_rgb  in  24  colour from ROM, {R,G,B}
- o_vga_r, o_vga_g, o_vga_b  out  8 each  pixel colour
- o_vga_hs  out  1  hsync, active low
- o_vga_vs  out  1  vsync, active low
- o_vga_blank_n  out  1  high during the visible region
- o_vga_sync_n  out  1  constant 0
- o_frame_start  out  1  one-i_clk pulse at frame origin

## Operation
- Counters: h_cnt 0..H_TOTAL-1 (800) and v_cnt 0..V_TOTAL-1 (525). h_cnt increments per tick. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. v_cnt wraps at V_TOTAL-1.
- run flag: 0 on reset; set on the first tick; never cleared except by reset.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- o_req = run && active.
- o_x = o_req ? h_cnt : 0; o_y = o_req ? v_cnt : 0. Both are driven combinationally from registers.
- hs_raw low for h_cnt in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC), i.e. [656,752).
- vs_raw low for v_cnt in [490,492).
- Control delay: {hs_raw, vs_raw, o_req} passes through a LATENCY-deep tick-enabled delay line. It is then registered together with i_rgb into the output stage.
- Output stage: blank_n = delayed o_req; rgb = delayed o_req ? i_rgb : 24'h0. RGB must be zero whenever blank_n=0.
- o_frame_start = run && i_en && h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1. It is also asserted on the very first tick after reset (run=0, i_en=1). It marks that the next address presented is (0,0).
- i_en=0: counters, delay line and outputs hold; o_frame_start=0.

## Timing
- Reset values: h_cnt=v_cnt=0, run=0, o_req=0, o_x=0, o_y=0, o_vga_hs=1, o_vga_vs=1, o_vga_blank_n=0, RGB=0, o_frame_start=0, delay line filled with idle (hs=1, vs=1, req=0).
- Address→output latency is LATENCY+1 ticks. Pixel (x,y) appears on the output LATENCY+1 ticks after o_x=x, o_y=y. Sync and blank carry identical delay, so relative alignment matches the raw counters.
- LATENCY=0 supports a purely combinational ROM, with i_rgb sampled in the same tick that o_x is presented.
- Reset mid-frame: all state returns to reset values immediately and asynchronously. The first tick after deassertion restarts at (0,0) with o_frame_start.
- Frame period is 800×525 = 420000 ticks. The line period is 800 ticks.

## Structure
- Package vga_pkg holds the default timing constants and the derived H_TOTAL/V_TOTAL, HS_START/HS_END, VS_START/VS_END. It also holds the rgb_t typedef (24-bit packed struct r/g/b).
- One sub-module, vga_delay_line: a parameterized-depth, width-generic, enable-gated shift register with a reset value parameter. It handles DEPTH=0 as a pass-through.

## Test plan
- Reset, then hold i_en=1 with LATENCY=0 and a model ROM that returns {x[7:0],y[7:0],8'hA5}. At the first tick, o_frame_start=1 and o_x=0/o_y=0. One tick later, o_vga_rgb=24'h0000A5 and blank_n=1.
- Count ticks across one line. o_vga_hs must be low for exactly 96 ticks, from output tick 657 to 752 (counting from line start at 1). blank_n must be high for exactly 640 ticks.
- Run a full frame. o_vga_vs must be low for 2 lines (1600 ticks). o_frame_start must pulse exactly once per 420000 ticks. o_req must be high for 307200 ticks.
- Set LATENCY=3 with the model ROM delayed by 3 ticks. Pixel (639,479) must output {8'h7F,8'hDF,8'hA5} exactly 4 ticks after its address. hs/blank edges must shift by 4 versus raw counters.
- Toggle i_en with a 50% pattern (pixel tick = clk/2). The output sequence must be identical to the i_en=1 run when sampled on ticks. All outputs must hold on i_en=0 cycles.
- Assert i_rst_n=0 mid-line at h_cnt=300, v_cnt=100. Outputs must go to reset values without waiting for a clock edge. After release, the next frame starts at (0,0) with o_frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA raster defaults, derived timing, colour type and scanner state encoding.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;

  localparam int unsigned H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int unsigned HS_START = DEF_H_ACTIVE + DEF_H_FRONT;
  localparam int unsigned HS_END   = HS_START + DEF_H_SYNC;
  localparam int unsigned VS_START = DEF_V_ACTIVE + DEF_V_FRONT;
  localparam int unsigned VS_END   = VS_START + DEF_V_SYNC;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with a reset fill value; DEPTH=0 is a wire.
module vga_delay_line #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       DEPTH   = 0,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, en};
      assign d_out     = d_in;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
        if (en) begin
          stage_d[0] = d_in;
          for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign d_out = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scanner.sv
// VGA raster initiator: counts h/v, requests ROM pixels, aligns returned colour
// with sync/blank after LATENCY ticks and drives the DAC bundle.
module vga_scanner
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned LATENCY  = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_req,
  input  logic [23:0] i_rgb,
  output logic [7:0]  o_vga_r,
  output logic [7:0]  o_vga_g,
  output logic [7:0]  o_vga_b,
  output logic        o_vga_hs,
  output logic        o_vga_vs,
  output logic        o_vga_blank_n,
  output logic        o_vga_sync_n,
  output logic        o_frame_start
);

  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST_C = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] HS_BEG_C = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END_C = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST_C = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] VS_BEG_C = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END_C = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  scan_state_e state_q, state_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  rgb_t        rgb_q, rgb_d;

  logic        run, active, at_last, hs_raw, vs_raw;
  logic [2:0]  ctl_raw, ctl_dly;

  assign run     = (state_q == ST_RUN);
  assign active  = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
  assign at_last = (h_cnt_q == H_LAST_C) && (v_cnt_q == V_LAST_C);
  assign hs_raw  = !((h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C));
  assign vs_raw  = !((v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C));

  assign o_req   = run && active;
  assign o_x     = o_req ? h_cnt_q : '0;
  assign o_y     = o_req ? v_cnt_q[8:0] : '0;
  assign ctl_raw = {hs_raw, vs_raw, o_req};

  // The first tick only arms the scanner, so (0,0) is presented right after it.
  assign o_frame_start = i_rst_n && i_en && (!run || at_last);

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (i_en) begin
      state_d = ST_RUN;
      if (run) begin
        if (h_cnt_q == H_LAST_C) begin
          h_cnt_d = '0;
          v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 10'd1;
        end else begin
          h_cnt_d = h_cnt_q + 10'd1;
        end
      end
    end
  end

  vga_delay_line #(
    .WIDTH  (3),
    .DEPTH  (LATENCY),
    .RST_VAL(3'b110)
  ) u_ctl_dly (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .en   (i_en),
    .d_in (ctl_raw),
    .d_out(ctl_dly)
  );

  always_comb begin
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    if (i_en) begin
      hs_d      = ctl_dly[2];
      vs_d      = ctl_dly[1];
      blank_n_d = ctl_dly[0];
      rgb_d     = rgb_t'(ctl_dly[0] ? i_rgb : 24'h0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  assign o_vga_r       = rgb_q.r;
  assign o_vga_g       = rgb_q.g;
  assign o_vga_b       = rgb_q.b;
  assign o_vga_hs      = hs_q;
  assign o_vga_vs      = vs_q;
  assign o_vga_blank_n = blank_n_q;
  assign o_vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scanner.sv
// Directed bench for vga_scanner: full-size line timing, reduced-size frames,
// LATENCY=3 alignment, half-rate pixel tick and asynchronous reset.
module tb_vga_scanner;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int lat;
  } cfg_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic        req;
    logic        hs;
    logic        vs;
    logic        bn;
    logic        fs;
    logic [23:0] rgb;
  } obs_t;

  localparam cfg_t C_FULL = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
  localparam cfg_t C_S0   = '{16, 2, 4, 3, 8, 2, 2, 3, 0};
  localparam cfg_t C_S3   = '{16, 2, 4, 3, 8, 2, 2, 3, 3};

  logic clk = 1'b0;
  logic rst_n;
  logic en_f, en_s, en_h;
  int   total = 0;
  int   bad   = 0;
  int   n_f, n_s, n_h;

  always #5 clk = ~clk;

  logic [9:0] x_f, x_s0, x_s3, x_h;
  logic [8:0] y_f, y_s0, y_s3, y_h;
  logic req_f, req_s0, req_s3, req_h;
  logic hs_f, hs_s0, hs_s3, hs_h;
  logic vs_f, vs_s0, vs_s3, vs_h;
  logic bn_f, bn_s0, bn_s3, bn_h;
  logic sn_f, sn_s0, sn_s3, sn_h;
  logic fs_f, fs_s0, fs_s3, fs_h;
  logic [7:0] r_f, g_f, b_f, r_s0, g_s0, b_s0, r_s3, g_s3, b_s3, r_h, g_h, b_h;
  logic [23:0] rom_f, rom_s0, rom_s3, rom_h;
  obs_t ob_f, ob_s0, ob_s3, ob_h;

  assign rom_f  = {x_f[7:0],  y_f[7:0],  8'hA5};
  assign rom_s0 = {x_s0[7:0], y_s0[7:0], 8'hA5};
  assign rom_h  = {x_h[7:0],  y_h[7:0],  8'hA5};

  logic [23:0] p0_s3 = '0;
  logic [23:0] p1_s3 = '0;
  logic [23:0] p2_s3 = '0;
  always @(posedge clk) begin
    if (en_s) begin
      p0_s3 <= {x_s3[7:0], y_s3[7:0], 8'hA5};
      p1_s3 <= p0_s3;
      p2_s3 <= p1_s3;
    end
  end
  assign rom_s3 = p2_s3;

  assign ob_f  = {x_f,  y_f,  req_f,  hs_f,  vs_f,  bn_f,  fs_f,  r_f,  g_f,  b_f};
  assign ob_s0 = {x_s0, y_s0, req_s0, hs_s0, vs_s0, bn_s0, fs_s0, r_s0, g_s0, b_s0};
  assign ob_s3 = {x_s3, y_s3, req_s3, hs_s3, vs_s3, bn_s3, fs_s3, r_s3, g_s3, b_s3};
  assign ob_h  = {x_h,  y_h,  req_h,  hs_h,  vs_h,  bn_h,  fs_h,  r_h,  g_h,  b_h};

  vga_scanner u_full (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_f),
    .o_x(x_f), .o_y(y_f), .o_req(req_f), .i_rgb(rom_f),
    .o_vga_r(r_f), .o_vga_g(g_f), .o_vga_b(b_f),
    .o_vga_hs(hs_f), .o_vga_vs(vs_f), .o_vga_blank_n(bn_f),
    .o_vga_sync_n(sn_f), .o_frame_start(fs_f)
  );

  vga_scanner #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .LATENCY(0)
  ) u_s0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_s),
    .o_x(x_s0), .o_y(y_s0), .o_req(req_s0), .i_rgb(rom_s0),
    .o_vga_r(r_s0), .o_vga_g(g_s0), .o_vga_b(b_s0),
    .o_vga_hs(hs_s0), .o_vga_vs(vs_s0), .o_vga_blank_n(bn_s0),
    .o_vga_sync_n(sn_s0), .o_frame_start(fs_s0)
  );

  vga_scanner #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .LATENCY(3)
  ) u_s3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_s),
    .o_x(x_s3), .o_y(y_s3), .o_req(req_s3), .i_rgb(rom_s3),
    .o_vga_r(r_s3), .o_vga_g(g_s3), .o_vga_b(b_s3),
    .o_vga_hs(hs_s3), .o_vga_vs(vs_s3), .o_vga_blank_n(bn_s3),
    .o_vga_sync_n(sn_s3), .o_frame_start(fs_s3)
  );

  vga_scanner #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .LATENCY(0)
  ) u_h (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_h),
    .o_x(x_h), .o_y(y_h), .o_req(req_h), .i_rgb(rom_h),
    .o_vga_r(r_h), .o_vga_g(g_h), .o_vga_b(b_h),
    .o_vga_hs(hs_h), .o_vga_vs(vs_h), .o_vga_blank_n(bn_h),
    .o_vga_sync_n(sn_h), .o_frame_start(fs_h)
  );

  // Expected outputs after n pixel ticks: address is raster position n-1,
  // the DAC bundle shows raster position n-2-lat (idle before that).
  function automatic obs_t model(cfg_t c, int n, logic en, logic rst);
    int   ht, ft, p, h, v;
    obs_t e;
    ht = c.ha + c.hf + c.hs + c.hb;
    ft = ht * (c.va + c.vf + c.vs + c.vb);
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (n >= 1) begin
      p = (n - 1) % ft;
      h = p % ht;
      v = p / ht;
      if (h < c.ha && v < c.va) begin
        e.req = 1'b1;
        e.x   = 10'(h);
        e.y   = 9'(v);
      end
    end
    p = n - c.lat - 2;
    if (p >= 0) begin
      p = p % ft;
      h = p % ht;
      v = p / ht;
      e.hs = !(h >= c.ha + c.hf && h < c.ha + c.hf + c.hs);
      e.vs = !(v >= c.va + c.vf && v < c.va + c.vf + c.vs);
      if (h < c.ha && v < c.va) begin
        e.bn  = 1'b1;
        e.rgb = {8'(h), 8'(v), 8'hA5};
      end
    end
    e.fs = rst && en && (n == 0 || (n - 1) % ft == ft - 1);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input obs_t ob, input obs_t e);
    chk(tag, {16'h0, ob}, {16'h0, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (en_f) n_f++;
      if (en_s) n_s++;
      if (en_h) n_h++;
    end
  endtask

  int hs_lo, hs_first, hs_last, bn_hi;
  int req_cnt, vs_cnt, fs_cnt, fs_last;
  int s3_hs_first, s3_req_fall, s3_bn_fall;
  logic s3_req_prev, s3_bn_prev;

  initial begin
    rst_n = 1'b0;
    en_f = 1'b0; en_s = 1'b0; en_h = 1'b0;
    n_f = 0; n_s = 0; n_h = 0;
    tick();
    tick();
    chk_dut("rst_full", ob_f,  model(C_FULL, 0, en_f, rst_n));
    chk_dut("rst_s0",   ob_s0, model(C_S0,   0, en_s, rst_n));
    chk_dut("rst_s3",   ob_s3, model(C_S3,   0, en_s, rst_n));
    chk_dut("rst_h",    ob_h,  model(C_S0,   0, en_h, rst_n));
    chk("sync_n", {60'h0, sn_f, sn_s0, sn_s3, sn_h}, 64'h0);
    rst_n = 1'b1;

    // Full-size line timing at LATENCY=0.
    en_f = 1'b1;
    #1;
    chk_dut("full_pre", ob_f, model(C_FULL, n_f, en_f, rst_n));
    chk("full_first_fs", {63'h0, fs_f}, 64'h1);
    hs_lo = 0; hs_first = 0; hs_last = 0; bn_hi = 0;
    for (int i = 0; i < 802; i++) begin
      tick();
      chk_dut("full_run", ob_f, model(C_FULL, n_f, en_f, rst_n));
      if (n_f == 1) chk("full_first_addr", {x_f, y_f, req_f}, {10'd0, 9'd0, 1'b1});
      if (n_f == 2) chk("full_first_pix", {bn_f, r_f, g_f, b_f}, {1'b1, 24'h0000A5});
      if (n_f >= 2 && n_f <= 801) begin
        if (!hs_f) begin
          hs_lo++;
          if (hs_first == 0) hs_first = n_f - 1;
          hs_last = n_f - 1;
        end
        if (bn_f) bn_hi++;
      end
    end
    chk("full_hs_width", hs_lo, 96);
    chk("full_hs_first", hs_first, 657);
    chk("full_hs_last", hs_last, 752);
    chk("full_blank_width", bn_hi, 640);
    en_f = 1'b0;

    // Reduced frames: LATENCY=0 and LATENCY=3 side by side.
    en_s = 1'b1;
    #1;
    chk_dut("s0_pre", ob_s0, model(C_S0, n_s, en_s, rst_n));
    chk_dut("s3_pre", ob_s3, model(C_S3, n_s, en_s, rst_n));
    req_cnt = 0; vs_cnt = 0; fs_cnt = 0; fs_last = -1;
    s3_hs_first = 0; s3_req_fall = 0; s3_bn_fall = 0;
    s3_req_prev = req_s3; s3_bn_prev = bn_s3;
    if (fs_s0) begin
      fs_cnt++;
      fs_last = n_s;
    end
    for (int i = 0; i < 750; i++) begin
      tick();
      chk_dut("s0_run", ob_s0, model(C_S0, n_s, en_s, rst_n));
      chk_dut("s3_run", ob_s3, model(C_S3, n_s, en_s, rst_n));
      if (n_s <= 375 && req_s0) req_cnt++;
      if (n_s >= 2 && n_s <= 376 && !vs_s0) vs_cnt++;
      if (fs_s0) begin
        fs_cnt++;
        if (fs_last >= 0) chk("s0_fs_period", n_s - fs_last, 375);
        fs_last = n_s;
      end
      if (n_s == 191) chk("s3_last_addr", {x_s3, y_s3, req_s3}, {10'd15, 9'd7, 1'b1});
      if (n_s == 195) chk("s3_last_pix", {bn_s3, r_s3, g_s3, b_s3}, {1'b1, 24'h0F07A5});
      if (!hs_s3 && s3_hs_first == 0) s3_hs_first = n_s;
      if (s3_req_prev && !req_s3 && s3_req_fall == 0) s3_req_fall = n_s;
      if (s3_bn_prev && !bn_s3 && s3_bn_fall == 0) s3_bn_fall = n_s;
      s3_req_prev = req_s3;
      s3_bn_prev  = bn_s3;
    end
    chk("s0_req_count", req_cnt, 128);
    chk("s0_vs_low", vs_cnt, 50);
    chk("s0_fs_count", fs_cnt, 3);
    chk("s3_hs_first", s3_hs_first, 23);
    chk("s3_req_fall", s3_req_fall, 17);
    chk("s3_blank_shift", s3_bn_fall - s3_req_fall, 4);
    en_s = 1'b0;

    // Half-rate pixel tick: outputs advance on enabled edges and hold otherwise.
    #1;
    chk_dut("h_pre", ob_h, model(C_S0, n_h, en_h, rst_n));
    for (int c = 0; c < 800; c++) begin
      en_h = (c % 2 == 0);
      tick();
      chk_dut(en_h ? "h_tick" : "h_hold", ob_h, model(C_S0, n_h, en_h, rst_n));
    end
    chk("h_ticks", n_h, 400);
    en_h = 1'b0;

    // Run to (10,3) and pull reset between clock edges.
    en_s = 1'b1;
    for (int i = 0; i < 86; i++) begin
      tick();
      chk_dut("s0_run2", ob_s0, model(C_S0, n_s, en_s, rst_n));
      chk_dut("s3_run2", ob_s3, model(C_S3, n_s, en_s, rst_n));
    end
    chk("s0_pre_reset_pos", {x_s0, y_s0}, {10'd10, 9'd3});
    #2;
    rst_n = 1'b0;
    #1;
    chk_dut("arst_full", ob_f,  model(C_FULL, 0, en_f, rst_n));
    chk_dut("arst_s0",   ob_s0, model(C_S0,   0, en_s, rst_n));
    chk_dut("arst_s3",   ob_s3, model(C_S3,   0, en_s, rst_n));
    chk_dut("arst_h",    ob_h,  model(C_S0,   0, en_h, rst_n));
    tick();
    chk_dut("arst_hold_s0", ob_s0, model(C_S0, 0, en_s, rst_n));
    n_f = 0; n_s = 0; n_h = 0;
    rst_n = 1'b1;
    #1;
    chk_dut("rel_s0_pre", ob_s0, model(C_S0, n_s, en_s, rst_n));
    chk("rel_fs", {63'h0, fs_s0}, 64'h1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_dut("rel_s0", ob_s0, model(C_S0, n_s, en_s, rst_n));
      chk_dut("rel_s3", ob_s3, model(C_S3, n_s, en_s, rst_n));
      if (n_s == 1) chk("rel_first_addr", {x_s0, y_s0, req_s0}, {10'd0, 9'd0, 1'b1});
    end
    chk("sync_n_run", {60'h0, sn_f, sn_s0, sn_s3, sn_h}, 64'h0);
    en_s = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
